// File: rtl/audio_dac_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_dac_i2s_tx
// Purpose  : Serializes buffered mono samples MSB-first onto an I2S DAC line,
//            sending the same word in both the left and right channels.
// Revision : 1.0 - initial release
// ============================================================================
module audio_dac_i2s_tx #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_clr_flags,
    output logic              o_aud_dacdat,
    output logic              o_sample_tick,
    output logic              o_underrun,
    output logic              o_overrun,
    output logic              o_frame_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              lrck_d1_q;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] cur_sample_q, cur_sample_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dacdat_q, dacdat_d;
    logic              tick_q, tick_d;
    logic              underrun_q, underrun_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;

    logic w_fall;
    logic w_rise;
    logic w_load;

    assign w_fall = lrck_d1_q & ~i_daclrck;
    assign w_rise = ~lrck_d1_q & i_daclrck;
    // Right-channel edges only matter once a left frame has started the stream.
    assign w_load = w_fall | (w_rise & (state_q != S_IDLE));

    always_comb begin
        state_d      = state_q;
        hold_data_d  = i_valid ? i_sample : hold_data_q;
        hold_full_d  = hold_full_q | i_valid;
        cur_sample_d = cur_sample_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        dacdat_d     = 1'b0;
        tick_d       = 1'b0;
        underrun_d   = underrun_q & ~i_clr_flags;
        overrun_d    = overrun_q & ~i_clr_flags;
        frame_err_d  = frame_err_q & ~i_clr_flags;

        // A left edge consumes the buffer before any concurrent write lands in it.
        if (w_fall) begin
            tick_d      = 1'b1;
            hold_full_d = i_valid;
            if (hold_full_q) begin
                cur_sample_d = hold_data_q;
            end else begin
                underrun_d = 1'b1;
            end
        end else if (i_valid && hold_full_q) begin
            overrun_d = 1'b1;
        end

        if (w_load) begin
            if ((state_q == S_SHIFT) && (cnt_q != C_LAST_BIT)) begin
                frame_err_d = 1'b1;
            end
            state_d  = S_SHIFT;
            dacdat_d = cur_sample_d[DATA_W-1];
            shift_d  = cur_sample_d << 1;
            cnt_d    = '0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (cnt_q == C_LAST_BIT) begin
                        state_d = S_WAIT;
                    end else begin
                        dacdat_d = shift_q[DATA_W-1];
                        shift_d  = shift_q << 1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                default: dacdat_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            lrck_d1_q    <= 1'b0;
            hold_data_q  <= '0;
            hold_full_q  <= 1'b0;
            cur_sample_q <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            dacdat_q     <= 1'b0;
            tick_q       <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrck_d1_q    <= i_daclrck;
            hold_data_q  <= hold_data_d;
            hold_full_q  <= hold_full_d;
            cur_sample_q <= cur_sample_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            dacdat_q     <= dacdat_d;
            tick_q       <= tick_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign o_aud_dacdat  = dacdat_q;
    assign o_sample_tick = tick_q;
    assign o_underrun    = underrun_q;
    assign o_overrun     = overrun_q;
    assign o_frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_dac_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_dac_i2s_tx
// Purpose  : Directed bench for audio_dac_i2s_tx with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_dac_i2s_tx;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              lrck;
    logic              valid;
    logic [DATA_W-1:0] sample;
    logic              clr;
    logic              dac, tick, und, ovr, ferr;

    int n_checks = 0;
    int n_fail   = 0;
    bit go       = 1'b0;

    logic [DATA_W-1:0] cap      = '0;
    logic              cap_tick = 1'b0;

    audio_dac_i2s_tx #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_daclrck    (lrck),
        .i_valid      (valid),
        .i_sample     (sample),
        .i_clr_flags  (clr),
        .o_aud_dacdat (dac),
        .o_sample_tick(tick),
        .o_underrun   (und),
        .o_overrun    (ovr),
        .o_frame_err  (ferr)
    );

    always #5 clk = ~clk;

    // Frame-level model: a word starts at each accepted LRCK edge and bit k of
    // the frame is word[DATA_W-1-k]; m_k counts clock edges since that start.
    bit                m_prev   = 1'b0;
    bit                m_active = 1'b0;
    int                m_k      = DATA_W + 2;
    logic [DATA_W-1:0] m_word   = '0;
    logic [DATA_W-1:0] m_cur    = '0;
    logic [DATA_W-1:0] m_hold   = '0;
    bit                m_full   = 1'b0;
    bit                m_tick   = 1'b0;
    bit                m_und    = 1'b0;
    bit                m_ovr    = 1'b0;
    bit                m_ferr   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 0; m_active = 0; m_k = DATA_W + 2; m_word = '0; m_cur = '0;
            m_hold = '0; m_full = 0; m_tick = 0; m_und = 0; m_ovr = 0; m_ferr = 0;
        end else begin
            bit fall, rise;
            fall   = m_prev && !lrck;
            rise   = !m_prev && lrck;
            m_und  = m_und && !clr;
            m_ovr  = m_ovr && !clr;
            m_ferr = m_ferr && !clr;
            m_tick = fall;
            if (valid && m_full && !fall) m_ovr = 1;
            if (fall) begin
                if (m_full) m_cur = m_hold;
                else        m_und = 1;
                m_full = valid;
            end else begin
                m_full = m_full || valid;
            end
            if (valid) m_hold = sample;
            if (fall || (rise && m_active)) begin
                if (m_active && (m_k < DATA_W - 1)) m_ferr = 1;
                m_active = 1;
                m_word   = m_cur;
                m_k      = 0;
            end else if (m_k < DATA_W + 2) begin
                m_k++;
            end
            m_prev = lrck;
        end
    end

    task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            logic exp_dat;
            exp_dat = (m_active && (m_k < DATA_W)) ? m_word[DATA_W-1-m_k] : 1'b0;
            report("model_dacdat", {31'd0, dac},  {31'd0, exp_dat});
            report("model_tick",   {31'd0, tick}, {31'd0, m_tick});
            report("model_under",  {31'd0, und},  {31'd0, m_und});
            report("model_over",   {31'd0, ovr},  {31'd0, m_ovr});
            report("model_ferr",   {31'd0, ferr}, {31'd0, m_ferr});
        end
    end

    // One LRCK half-frame of n cycles; optional writes at cycles wa/wb and a
    // flag clear at cycle ca. Captures the first DATA_W line bits and the tick.
    task automatic half(input logic lv, input int n,
                        input int wa, input logic [DATA_W-1:0] va,
                        input int wb, input logic [DATA_W-1:0] vb,
                        input int ca);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= DATA_W) cap = {cap[DATA_W-2:0], dac};
            if (c == 1) cap_tick = tick;
            if (c == 0) lrck = lv;
            valid  = (c == wa) || (c == wb);
            sample = (c == wb) ? vb : va;
            clr    = (c == ca);
        end
    endtask

    initial begin
        rst_n = 1'b1; lrck = 1'b0; valid = 1'b0; sample = '0; clr = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        report("reset_dacdat", {31'd0, dac},  32'd0);
        report("reset_tick",   {31'd0, tick}, 32'd0);
        report("reset_flags",  {29'd0, und, ovr, ferr}, 32'd0);
        go = 1'b1;
        rst_n = 1'b1;

        // Basic serialize; the first rising edge is ignored from idle.
        half(1'b1, 32, 5, 16'hA5C3, -1, 16'h0, -1);
        report("idle_rise_quiet", {16'd0, cap}, 32'd0);
        half(1'b0, 32, -1, 16'h0, -1, 16'h0, -1);
        report("basic_left_word", {16'd0, cap}, 32'h0000A5C3);
        report("basic_left_tick", {31'd0, cap_tick}, 32'd1);
        half(1'b1, 32, -1, 16'h0, -1, 16'h0, -1);
        report("basic_right_word", {16'd0, cap}, 32'h0000A5C3);
        report("basic_right_tick", {31'd0, cap_tick}, 32'd0);
        report("basic_no_under", {31'd0, und}, 32'd0);

        // Underrun: same sample resent, then cleared.
        half(1'b0, 32, -1, 16'h0, -1, 16'h0, -1);
        report("underrun_word", {16'd0, cap}, 32'h0000A5C3);
        report("underrun_flag", {31'd0, und}, 32'd1);

        // Overrun: two writes in one frame, the later one wins.
        half(1'b1, 32, 5, 16'h0001, 10, 16'h7FFF, 2);
        report("underrun_cleared", {31'd0, und}, 32'd0);
        report("overrun_flag", {31'd0, ovr}, 32'd1);
        half(1'b0, 32, -1, 16'h0, -1, 16'h0, -1);
        report("overrun_word", {16'd0, cap}, 32'h00007FFF);

        // Write coinciding with the left edge.
        half(1'b1, 32, 5, 16'h1234, -1, 16'h0, 2);
        report("flags_cleared", {29'd0, und, ovr, ferr}, 32'd0);
        half(1'b0, 32, 0, 16'h5678, -1, 16'h0, -1);
        report("simul_now_word", {16'd0, cap}, 32'h00001234);
        report("simul_no_flags", {29'd0, und, ovr, ferr}, 32'd0);
        half(1'b1, 32, -1, 16'h0, -1, 16'h0, -1);
        half(1'b0, 32, -1, 16'h0, -1, 16'h0, -1);
        report("simul_next_word", {16'd0, cap}, 32'h00005678);
        report("simul_next_no_under", {31'd0, und}, 32'd0);

        // Short half-frame: the new frame starts in the edge cycle.
        half(1'b1, 8, -1, 16'h0, -1, 16'h0, -1);
        half(1'b0, 32, -1, 16'h0, -1, 16'h0, -1);
        report("short_frame_err", {31'd0, ferr}, 32'd1);
        report("short_new_word", {16'd0, cap}, 32'h00005678);

        // Exactly DATA_W-cycle half-frames are legal.
        half(1'b1, 32, 3, 16'h0F0F, -1, 16'h0, 2);
        half(1'b0, 16, -1, 16'h0, -1, 16'h0, -1);
        half(1'b1, 16, -1, 16'h0, -1, 16'h0, -1);
        half(1'b0, 32, -1, 16'h0, -1, 16'h0, -1);
        report("exact_no_ferr", {31'd0, ferr}, 32'd0);
        report("exact_word", {16'd0, cap}, 32'h00000F0F);

        // Asynchronous reset in the middle of a word.
        half(1'b1, 32, 3, 16'hFFFF, -1, 16'h0, -1);
        @(negedge clk); lrck = 1'b0;
        repeat (4) @(negedge clk);
        report("midword_bit", {31'd0, dac}, 32'd1);
        #2 rst_n = 1'b0;
        #1 report("async_reset_dacdat", {31'd0, dac}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        half(1'b1, 32, 4, 16'h8001, -1, 16'h0, -1);
        report("post_reset_rise_ignored", {16'd0, cap}, 32'd0);
        half(1'b0, 32, -1, 16'h0, -1, 16'h0, -1);
        report("post_reset_word", {16'd0, cap}, 32'h00008001);
        report("post_reset_tick", {31'd0, cap_tick}, 32'd1);
        report("post_reset_no_under", {31'd0, und}, 32'd0);
        half(1'b1, 4, -1, 16'h0, -1, 16'h0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
